// File: rtl/regfile_sb_if.sv
// Bundle of read, write, issue and flush signals for regfile_sb.
// Master drives addresses/writes/issue; slave returns read data and busy state.
interface regfile_sb_if #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0]   ra;
  logic [NUM_RD*XLEN-1:0] rdata;
  logic [NUM_RD-1:0]      rbusy;
  logic [NUM_WR-1:0]      we;
  logic [NUM_WR*AW-1:0]   wa;
  logic [NUM_WR*XLEN-1:0] wd;
  logic                   iss_valid;
  logic [AW-1:0]          iss_rd;
  logic                   flush;
  logic                   any_busy;

  // No handshake: every field is sampled or produced every cycle.
  modport master (
    output ra, we, wa, wd, iss_valid, iss_rd, flush,
    input  rdata, rbusy, any_busy
  );
  modport slave (
    input  ra, we, wa, wd, iss_valid, iss_rd, flush,
    output rdata, rbusy, any_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass, fixed-priority writes and a
// busy-bit scoreboard (issue sets, writeback clears, flush clears all).
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [AW-1:0]     wr_addr [NUM_WR];
  logic [XLEN-1:0]   wr_data [NUM_WR];
  logic [NUM_WR-1:0] wr_keep;
  logic [AW-1:0]     rd_addr [NUM_RD];
  logic [NUM_RD-1:0] rd_hit;
  logic              iss_keep;

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wr_addr[j] = bus.wa[j*AW +: AW];
    assign wr_data[j] = bus.wd[j*XLEN +: XLEN];
    assign wr_keep[j] = bus.we[j] && !(ZERO_REG != 0 && wr_addr[j] == '0);
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign rd_addr[k] = bus.ra[k*AW +: AW];
  end

  assign iss_keep = bus.iss_valid && !(ZERO_REG != 0 && bus.iss_rd == '0);

  // Clear first, then set, then flush: set beats clear, flush beats both.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.we[j]) busy_nxt[wr_addr[j]] = 1'b0;
    end
    if (iss_keep) busy_nxt[bus.iss_rd] = 1'b1;
    if (bus.flush) busy_nxt = '0;
  end

  // Ascending port order means the highest-index port's NBA lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_keep[j]) mem[wr_addr[j]] <= wr_data[j];
      end
      busy <= busy_nxt;
    end
  end

  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    rd_hit    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rdata[k*XLEN +: XLEN] = mem[rd_addr[k]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.we[j] && wr_addr[j] == rd_addr[k]) begin
          bus.rdata[k*XLEN +: XLEN] = wr_data[j];
          rd_hit[k] = 1'b1;
        end
      end
      bus.rbusy[k] = busy[rd_addr[k]] & ~rd_hit[k];
      if (ZERO_REG != 0 && rd_addr[k] == '0) begin
        bus.rdata[k*XLEN +: XLEN] = '0;
        bus.rbusy[k] = 1'b0;
      end
    end
  end

  assign bus.any_busy = |busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: integer instance (x0 fixed) plus an
// F-file instance (f0 writable), checked against a queue of expectations.
module tb_regfile_sb;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mdl [32];

  regfile_sb_if #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bi ();
  regfile_sb_if #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bf ();

  regfile_sb #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) u_int (
    .clk(clk), .rst_n(rst_n), .bus(bi)
  );
  regfile_sb #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(bf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bi.ra = '0; bi.we = '0; bi.wa = '0; bi.wd = '0;
    bi.iss_valid = 1'b0; bi.iss_rd = '0; bi.flush = 1'b0;
    bf.ra = '0; bf.we = '0; bf.wa = '0; bf.wd = '0;
    bf.iss_valid = 1'b0; bf.iss_rd = '0; bf.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h but no expectation queued", tag, obs);
      return;
    end
    exp_v = exp_q.pop_front();
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    bi.ra = {a1, a0};
  endtask

  task automatic read_all_vs_model(input string tag);
    for (int a = 0; a < 32; a++) begin
      logic [4:0] a0, a1;
      a0 = 5'(a);
      a1 = 5'(31 - a);
      @(negedge clk);
      set_ra(a0, a1);
      exp_q.push_back((a0 == 0) ? 32'h0 : mdl[a0]);
      exp_q.push_back((a1 == 0) ? 32'h0 : mdl[a1]);
      #1;
      chk({tag, "_rd0"}, bi.rdata[31:0]);
      chk({tag, "_rd1"}, bi.rdata[63:32]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state on every address/port.
    read_all_vs_model("reset");
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      set_ra(5'(a), 5'(31 - a));
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1;
      chk("reset_rbusy0", 32'(bi.rbusy[0]));
      chk("reset_rbusy1", 32'(bi.rbusy[1]));
    end
    exp_q.push_back(32'h0);
    chk("reset_any_busy", 32'(bi.any_busy));

    // Write burst with issues, then reset lands mid-cycle with writes on we.
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d0, d1;
      d0 = $urandom;
      d1 = $urandom;
      bi.we = 2'b11;
      bi.wa = {5'(i + 17), 5'(i + 1)};
      bi.wd = {d1, d0};
      bi.iss_valid = 1'b1;
      bi.iss_rd = 5'(i + 24);
      mdl[i + 1] = d0;
      mdl[i + 17] = d1;
      tick();
    end
    bi.we = 2'b00;
    bi.iss_valid = 1'b0;
    set_ra(5'd1, 5'd20);
    exp_q.push_back(mdl[1]);
    exp_q.push_back(mdl[20]);
    exp_q.push_back(32'h1);
    #1;
    chk("burst_rd0", bi.rdata[31:0]);
    chk("burst_rd1", bi.rdata[63:32]);
    chk("burst_any_busy", 32'(bi.any_busy));
    tick();
    bi.we = 2'b11;
    bi.wa = {5'd2, 5'd1};
    bi.wd = {32'hA5A5A5A5, 32'h5A5A5A5A};
    bi.iss_valid = 1'b1;
    bi.iss_rd = 5'd6;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    read_all_vs_model("midreset");
    exp_q.push_back(32'h0);
    chk("midreset_any_busy", 32'(bi.any_busy));

    // x0 ignores writes and issue; f0 behaves as an ordinary register.
    tick();
    bi.we = 2'b01; bi.wa = '0; bi.wd = {32'h0, 32'hDEADBEEF};
    bi.iss_valid = 1'b1; bi.iss_rd = 5'd0; bi.ra = '0;
    bf.we = 2'b01; bf.wa = '0; bf.wd = {32'h0, 32'hDEADBEEF};
    bf.iss_valid = 1'b1; bf.iss_rd = 5'd0; bf.ra = '0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h0);
    #1;
    chk("x0_byp_rdata", bi.rdata[31:0]);
    chk("x0_byp_rbusy", 32'(bi.rbusy[0]));
    chk("f0_byp_rdata", bf.rdata[31:0]);
    chk("f0_byp_rbusy", 32'(bf.rbusy[0]));
    tick();
    idle();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    #1;
    chk("x0_rdata", bi.rdata[31:0]);
    chk("x0_rbusy", 32'(bi.rbusy[0]));
    chk("x0_any_busy", 32'(bi.any_busy));
    chk("f0_rdata", bf.rdata[31:0]);
    chk("f0_rbusy", 32'(bf.rbusy[0]));
    chk("f0_any_busy", 32'(bf.any_busy));

    // Same-cycle bypass on both read ports.
    bi.we = 2'b01; bi.wa = {5'd0, 5'd5}; bi.wd = {32'h0, 32'h12345678};
    set_ra(5'd5, 5'd5);
    mdl[5] = 32'h12345678;
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h12345678);
    #1;
    chk("byp_rd0", bi.rdata[31:0]);
    chk("byp_rd1", bi.rdata[63:32]);
    tick();
    bi.we = 2'b00;
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h12345678);
    #1;
    chk("stored_rd0", bi.rdata[31:0]);
    chk("stored_rd1", bi.rdata[63:32]);

    // Write conflict: port 1 wins.
    bi.we = 2'b11; bi.wa = {5'd7, 5'd7}; bi.wd = {32'h2222, 32'h1111};
    set_ra(5'd7, 5'd5);
    mdl[7] = 32'h2222;
    exp_q.push_back(32'h2222);
    #1;
    chk("conflict_byp", bi.rdata[31:0]);
    tick();
    bi.we = 2'b00;
    exp_q.push_back(32'h2222);
    #1;
    chk("conflict_stored", bi.rdata[31:0]);

    // Scoreboard: issue, writeback, then issue+writeback in one cycle.
    bi.iss_valid = 1'b1; bi.iss_rd = 5'd3;
    set_ra(5'd3, 5'd0);
    exp_q.push_back(32'h0);
    #1;
    chk("iss_same_cycle_rbusy", 32'(bi.rbusy[0]));
    tick();
    bi.iss_valid = 1'b0;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    #1;
    chk("iss_rbusy", 32'(bi.rbusy[0]));
    chk("iss_any_busy", 32'(bi.any_busy));
    bi.we = 2'b01; bi.wa = {5'd0, 5'd3}; bi.wd = {32'h0, 32'h00000ABC};
    mdl[3] = 32'h00000ABC;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h00000ABC);
    #1;
    chk("wb_rbusy", 32'(bi.rbusy[0]));
    chk("wb_rdata", bi.rdata[31:0]);
    tick();
    bi.we = 2'b00;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    chk("wb_done_rbusy", 32'(bi.rbusy[0]));
    chk("wb_done_any_busy", 32'(bi.any_busy));
    bi.iss_valid = 1'b1; bi.iss_rd = 5'd3;
    bi.we = 2'b10; bi.wa = {5'd3, 5'd0}; bi.wd = {32'h00000DEF, 32'h0};
    mdl[3] = 32'h00000DEF;
    tick();
    bi.we = 2'b00;
    bi.iss_rd = 5'd9;
    exp_q.push_back(32'h1);
    #1;
    chk("set_wins_rbusy", 32'(bi.rbusy[0]));
    tick();
    bi.iss_rd = 5'd12;
    tick();
    bi.iss_valid = 1'b0;
    set_ra(5'd9, 5'd12);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    #1;
    chk("pre_flush_rbusy9", 32'(bi.rbusy[0]));
    chk("pre_flush_rbusy12", 32'(bi.rbusy[1]));
    chk("pre_flush_any_busy", 32'(bi.any_busy));

    // Flush beats a same-cycle issue; the same-cycle write still lands.
    bi.flush = 1'b1; bi.iss_valid = 1'b1; bi.iss_rd = 5'd9;
    bi.we = 2'b10; bi.wa = {5'd12, 5'd0}; bi.wd = {32'hCAFEF00D, 32'h0};
    mdl[12] = 32'hCAFEF00D;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hCAFEF00D);
    #1;
    chk("flush_byp_rbusy12", 32'(bi.rbusy[1]));
    chk("flush_byp_rdata12", bi.rdata[63:32]);
    tick();
    idle();
    set_ra(5'd9, 5'd12);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hCAFEF00D);
    #1;
    chk("flush_any_busy", 32'(bi.any_busy));
    chk("flush_rbusy9", 32'(bi.rbusy[0]));
    chk("flush_rbusy12", 32'(bi.rbusy[1]));
    chk("flush_rdata12", bi.rdata[63:32]);
    set_ra(5'd3, 5'd0);
    exp_q.push_back(32'h0);
    #1;
    chk("flush_rbusy3", 32'(bi.rbusy[0]));

    // Random writes on both ports, including address collisions and x0.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  w;
      logic [4:0]  a0, a1;
      logic [31:0] d0, d1;
      w  = 2'($urandom_range(0, 3));
      a0 = 5'($urandom_range(0, 31));
      a1 = (i % 5 == 0) ? a0 : 5'($urandom_range(0, 31));
      d0 = $urandom;
      d1 = $urandom;
      bi.we = w; bi.wa = {a1, a0}; bi.wd = {d1, d0};
      if (w[0] && a0 != 0) mdl[a0] = d0;
      if (w[1] && a1 != 0) mdl[a1] = d1;
      tick();
    end
    idle();
    read_all_vs_model("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
